vic_int_arb: RTL and testbench
==============================

// Module: vic_int_arb
// PURPOSE
//  Receives the 32 pending-interrupt lines driven by the wake-up interrupt controller (WIC).
//  Arbitrates them by per-source priority and presents a single request plus vector to the core.
//  Holds the request until the core acknowledges, then reports the taken source back as a pending-clear pulse.
//  Sits between the WIC outputs (pad_vic_int_vld/pad_vic_int_cfg) and the CPU interrupt inputs, in the wic_clk domain.
// PARAMETERS
//  NUM_INT  32  number of interrupt sources; fixed at 32, so the vector is 5 bits
//  PRIO_W   2   priority bits per source; higher value = higher priority
// PORTS
//  wic_clk            in   1         block clock
//  pad_cpu_rst_b      in   1         async reset, active low
//  pad_vic_int_vld    in   32        pending lines from WIC
//  pad_vic_int_cfg    in   32        per-source mode: 0 = level, 1 = pulse (rising edge latched)
//  vic_int_en         in   32        per-source enable
//  vic_int_prio       in   32*PRIO_W source n priority = [n*PRIO_W +: PRIO_W]
//  cpu_vic_int_ack    in   1         one-cycle pulse: core takes the presented interrupt
//  cpu_vic_int_exit   in   1         one-cycle pulse: core finished the active handler
//  vic_cpu_int_req    out  1         interrupt request to core
//  vic_cpu_int_vec    out  5         vector of the presented/active source
//  vic_cpu_int_prio   out  PRIO_W    priority of the presented/active source
//  vic_int_active     out  1         handler in progress (ACK received, EXIT not yet received)
//  vic_wic_pend_clr   out  32        one-hot, one-cycle pulse on ACK; drives the WIC pending clear
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; pulse-pending register 0; edge-detect register 0.
//  Pulse sources:
//   - edge_ff <= pad_vic_int_vld every cycle.
//   - pend_p[n] is set on vld & ~edge_ff and cleared by pend_clr[n].
//   - If set and clear fall in the same cycle, set wins.
//  Effective pending: eff[n] = vic_int_en[n] & (cfg[n] ? pend_p[n] : vld[n]).
//  Arbitration (combinational over eff):
//   - Winner is the highest priority.
//   - Ties go to the lowest index.
//   - The winner, its priority and an any-pending flag are registered: 1 cycle of arbitration latency.
//  FSM:
//   - IDLE -> REQ: registered any-pending flag is 1. Latch vec/prio; req=1 on the next edge.
//     Earliest req is 2 cycles after eff rises.
//   - REQ: vec/prio held stable and never re-arbitrated.
//   - REQ -> ACTIVE: on ack.
//     - req=0, active=1.
//     - pend_clr[vec]=1 for exactly one cycle.
//     - pend_p[vec] is cleared.
//   - REQ -> IDLE (withdraw): eff[vec]=0 and no ack in the same cycle. req=0, no pend_clr.
//     ACK and withdraw in the same cycle: ACK wins.
//   - ACTIVE -> IDLE: on exit. active=0; vec/prio hold their last value until the next REQ.
//     There is no nesting or preemption in ACTIVE. New pending sources wait and are arbitrated after return to IDLE.
//  Ignored strobes: ack outside REQ and exit outside ACTIVE, with no side effects.
//  Reset asserted mid-operation: immediate return to the reset values; any in-flight request is dropped without pend_clr.
//  Width rules:
//   - Priority compare is unsigned PRIO_W bits.
//   - vec is 5 bits.
//   - pend_clr is always either 0 or one-hot.
// TESTING
//  1 Level src 3 (prio 1) en, vld[3]=1 -> req=1 at cycle 2, vec=3, prio=1. Ack -> pend_clr=32'h8 for one cycle, active=1. Exit -> IDLE.
//  2 Srcs 5 (prio 2) and 9 (prio 3) raised together -> vec=9. After exit, src 5 still pending -> vec=5.
//  3 Srcs 4 and 7, both prio 2 -> vec=4. Src 7 disabled via vic_int_en -> never presented.
//  4 Pulse src 19 (cfg=1), one-cycle vld -> req=1, vec=19 persists after vld drops. Ack -> pend_p[19]=0. New edge on the ack cycle -> re-presented after exit.
//  5 Level src 2 in REQ, vld[2] drops without ack -> req=0 next cycle, pend_clr=0. With ack in the same cycle -> ACTIVE, pend_clr=32'h4.
//  6 Ack in IDLE and exit in REQ -> no state change. Reset asserted in ACTIVE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/vic_int_arb.sv
// Arbitrates 32 WIC pending lines by priority and presents one request/vector to the core.
// Latency: 2 cycles from effective pending to request; holds request until ack, withdraw or reset.
module vic_int_arb #(
    parameter int NUM_INT = 32,
    parameter int PRIO_W  = 2
) (
    input  logic                      wic_clk,
    input  logic                      pad_cpu_rst_b,
    input  logic [NUM_INT-1:0]        pad_vic_int_vld,
    input  logic [NUM_INT-1:0]        pad_vic_int_cfg,
    input  logic [NUM_INT-1:0]        vic_int_en,
    input  logic [NUM_INT*PRIO_W-1:0] vic_int_prio,
    input  logic                      cpu_vic_int_ack,
    input  logic                      cpu_vic_int_exit,
    output logic                      vic_cpu_int_req,
    output logic [4:0]                vic_cpu_int_vec,
    output logic [PRIO_W-1:0]         vic_cpu_int_prio,
    output logic                      vic_int_active,
    output logic [NUM_INT-1:0]        vic_wic_pend_clr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [NUM_INT-1:0]  edge_ff;
    logic [NUM_INT-1:0]  pend_p;
    logic [NUM_INT-1:0]  eff;
    logic [NUM_INT-1:0]  take_vec;
    logic                win_vld;
    logic [4:0]          win_vec;
    logic [PRIO_W-1:0]   win_prio;
    logic                arb_vld;
    logic [4:0]          arb_vec;
    logic [PRIO_W-1:0]   arb_prio;
    logic                take;
    logic                load;

    assign eff = vic_int_en & ((pad_vic_int_cfg & pend_p) | (~pad_vic_int_cfg & pad_vic_int_vld));

    // Strict greater-than keeps the lowest index on a priority tie.
    always_comb begin
        win_vld  = 1'b0;
        win_vec  = '0;
        win_prio = '0;
        for (int n = 0; n < NUM_INT; n++) begin
            if (eff[n] && (!win_vld || (vic_int_prio[n*PRIO_W +: PRIO_W] > win_prio))) begin
                win_vld  = 1'b1;
                win_vec  = 5'(n);
                win_prio = vic_int_prio[n*PRIO_W +: PRIO_W];
            end
        end
    end

    always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            arb_vld  <= 1'b0;
            arb_vec  <= '0;
            arb_prio <= '0;
        end else begin
            arb_vld  <= win_vld;
            arb_vec  <= win_vec;
            arb_prio <= win_prio;
        end
    end

    always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_vld) state_nxt = REQ;
            REQ: begin
                if (cpu_vic_int_ack)             state_nxt = ACTIVE;
                else if (!eff[vic_cpu_int_vec])  state_nxt = IDLE;
            end
            ACTIVE:  if (cpu_vic_int_exit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        vic_cpu_int_req = (state == REQ);
        vic_int_active  = (state == ACTIVE);
        take            = (state == REQ) && cpu_vic_int_ack;
        load            = (state == IDLE) && arb_vld;
    end

    assign take_vec = take ? (NUM_INT'(1) << vic_cpu_int_vec) : '0;

    // Pulse pending is cleared on the ack edge itself so it cannot re-win after exit;
    // a fresh edge in the same cycle survives the clear.
    always_ff @(posedge wic_clk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            edge_ff          <= '0;
            pend_p           <= '0;
            vic_wic_pend_clr <= '0;
            vic_cpu_int_vec  <= '0;
            vic_cpu_int_prio <= '0;
        end else begin
            edge_ff          <= pad_vic_int_vld;
            pend_p           <= (pend_p & ~take_vec) | (pad_vic_int_vld & ~edge_ff);
            vic_wic_pend_clr <= take_vec;
            if (load) begin
                vic_cpu_int_vec  <= arb_vec;
                vic_cpu_int_prio <= arb_prio;
            end
        end
    end

endmodule

// File: tb/tb_vic_int_arb.sv
// Directed checks of vic_int_arb: latency, priority/tie arbitration, pulse latching, withdraw, strobes, reset.
module tb_vic_int_arb;

    logic        clk;
    logic        rst_n;
    logic [31:0] vld;
    logic [31:0] cfg;
    logic [31:0] en;
    logic [63:0] prio;
    logic        ack;
    logic        ext;
    logic        req;
    logic [4:0]  vec;
    logic [1:0]  oprio;
    logic        active;
    logic [31:0] pend_clr;

    int n_tests = 0;
    int n_fail  = 0;

    vic_int_arb #(.NUM_INT(32), .PRIO_W(2)) dut (
        .wic_clk          (clk),
        .pad_cpu_rst_b    (rst_n),
        .pad_vic_int_vld  (vld),
        .pad_vic_int_cfg  (cfg),
        .vic_int_en       (en),
        .vic_int_prio     (prio),
        .cpu_vic_int_ack  (ack),
        .cpu_vic_int_exit (ext),
        .vic_cpu_int_req  (req),
        .vic_cpu_int_vec  (vec),
        .vic_cpu_int_prio (oprio),
        .vic_int_active   (active),
        .vic_wic_pend_clr (pend_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic do_exit();
        ext = 1'b1;
        tick();
        ext = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        vld = '0; cfg = '0; en = '0; prio = '0; ack = 1'b0; ext = 1'b0;
        tick(2);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_vec", {27'd0, vec}, 32'd0);
        chk("rst_clr", pend_clr, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: level source 3, priority 1
        prio[7:6] = 2'd1; en[3] = 1'b1; vld[3] = 1'b1;
        tick();
        chk("t1_req_c1", {31'd0, req}, 32'd0);
        tick();
        chk("t1_req_c2", {31'd0, req}, 32'd1);
        chk("t1_vec", {27'd0, vec}, 32'd3);
        chk("t1_prio", {30'd0, oprio}, 32'd1);
        do_ack();
        chk("t1_clr", pend_clr, 32'h8);
        chk("t1_active", {31'd0, active}, 32'd1);
        chk("t1_req_off", {31'd0, req}, 32'd0);
        vld[3] = 1'b0;
        tick();
        chk("t1_clr_once", pend_clr, 32'd0);
        do_exit();
        chk("t1_exit", {31'd0, active}, 32'd0);
        chk("t1_vec_hold", {27'd0, vec}, 32'd3);
        tick(3);
        chk("t1_idle", {31'd0, req}, 32'd0);
        en = '0; prio = '0;

        // 2: src 5 prio 2 vs src 9 prio 3
        prio[11:10] = 2'd2; prio[19:18] = 2'd3;
        en[5] = 1'b1; en[9] = 1'b1; vld[5] = 1'b1; vld[9] = 1'b1;
        tick(2);
        chk("t2_req", {31'd0, req}, 32'd1);
        chk("t2_vec9", {27'd0, vec}, 32'd9);
        chk("t2_prio3", {30'd0, oprio}, 32'd3);
        do_ack();
        chk("t2_clr9", pend_clr, 32'h200);
        vld[9] = 1'b0;
        tick(2);
        chk("t2_no_nest", {31'd0, req}, 32'd0);
        do_exit();
        tick();
        chk("t2_req5", {31'd0, req}, 32'd1);
        chk("t2_vec5", {27'd0, vec}, 32'd5);
        chk("t2_prio2", {30'd0, oprio}, 32'd2);
        do_ack();
        vld[5] = 1'b0;
        do_exit();
        tick(3);
        en = '0; prio = '0;

        // 3: tie between 4 and 7 at prio 2, then 7 disabled
        prio[9:8] = 2'd2; prio[15:14] = 2'd2;
        en[4] = 1'b1; en[7] = 1'b1; vld[4] = 1'b1; vld[7] = 1'b1;
        tick(2);
        chk("t3_vec4", {27'd0, vec}, 32'd4);
        do_ack();
        chk("t3_clr4", pend_clr, 32'h10);
        vld[4] = 1'b0; en[7] = 1'b0;
        do_exit();
        tick(4);
        chk("t3_dis7", {31'd0, req}, 32'd0);
        vld[7] = 1'b0; en = '0; prio = '0;
        tick();

        // 4: pulse source 19
        cfg[19] = 1'b1; en[19] = 1'b1; prio[39:38] = 2'd1;
        vld[19] = 1'b1;
        tick();
        vld[19] = 1'b0;
        tick();
        chk("t4_req_c2", {31'd0, req}, 32'd0);
        tick();
        chk("t4_req", {31'd0, req}, 32'd1);
        chk("t4_vec19", {27'd0, vec}, 32'd19);
        tick(3);
        chk("t4_persist", {31'd0, req}, 32'd1);
        vld[19] = 1'b1;
        do_ack();
        vld[19] = 1'b0;
        chk("t4_clr19", pend_clr, 32'h80000);
        chk("t4_active", {31'd0, active}, 32'd1);
        do_exit();
        tick();
        chk("t4_repres", {31'd0, req}, 32'd1);
        chk("t4_vec_re", {27'd0, vec}, 32'd19);
        do_ack();
        do_exit();
        tick(4);
        chk("t4_cleared", {31'd0, req}, 32'd0);
        cfg = '0; en = '0; prio = '0;

        // 5: withdraw, then withdraw coinciding with ack
        en[2] = 1'b1; vld[2] = 1'b1;
        tick(2);
        chk("t5_req", {31'd0, req}, 32'd1);
        vld[2] = 1'b0;
        tick();
        chk("t5_withdraw", {31'd0, req}, 32'd0);
        chk("t5_wd_clr", pend_clr, 32'd0);
        chk("t5_wd_act", {31'd0, active}, 32'd0);
        vld[2] = 1'b1;
        tick(2);
        chk("t5_req2", {31'd0, req}, 32'd1);
        vld[2] = 1'b0;
        do_ack();
        chk("t5_ack_wins", {31'd0, active}, 32'd1);
        chk("t5_clr2", pend_clr, 32'h4);
        do_exit();
        tick(2);
        en = '0;

        // 6: ignored strobes and async reset
        do_ack();
        chk("t6_ack_idle", {31'd0, req | active}, 32'd0);
        chk("t6_ack_idle_clr", pend_clr, 32'd0);
        prio[7:6] = 2'd1; en[3] = 1'b1; vld[3] = 1'b1;
        tick(2);
        do_exit();
        chk("t6_exit_req", {31'd0, req}, 32'd1);
        chk("t6_exit_act", {31'd0, active}, 32'd0);
        do_ack();
        chk("t6_active", {31'd0, active}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_act", {31'd0, active}, 32'd0);
        chk("t6_rst_req", {31'd0, req}, 32'd0);
        chk("t6_rst_vec", {27'd0, vec}, 32'd0);
        chk("t6_rst_prio", {30'd0, oprio}, 32'd0);
        chk("t6_rst_clr", pend_clr, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
